// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message feeder: FSM encodings, round and
// length limits, padding constants and a byte-lane placement helper.
package sha1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_PAD  = 3'd4
    } state_e;

    localparam int SHA1_MAX_BYTES   = 55;
    localparam int SHA1_ROUND_FIRST = 1;
    localparam int SHA1_ROUND_LAST  = 80;
    localparam int SHA1_ROUND_FINAL = SHA1_ROUND_LAST + 1;

    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // PAD is a sub-phase of LOAD as far as the core is concerned.
    function automatic logic [1:0] core_state_enc(input state_e s);
        logic [1:0] enc;
        enc = 2'd0;
        case (s)
            ST_IDLE: enc = 2'd0;
            ST_LOAD: enc = 2'd1;
            ST_PAD:  enc = 2'd1;
            ST_RUN:  enc = 2'd2;
            ST_DONE: enc = 2'd3;
            default: enc = 2'd0;
        endcase
        return enc;
    endfunction

    // Big-endian placement: lane 0 is the most significant byte of the word.
    function automatic logic [31:0] byte_lane(input logic [7:0] b, input logic [1:0] lane);
        logic [31:0] w;
        w = 32'd0;
        case (lane)
            2'd0: w = {b, 24'd0};
            2'd1: w = {8'd0, b, 16'd0};
            2'd2: w = {16'd0, b, 8'd0};
            2'd3: w = {24'd0, b};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha1_pad_buffer.sv
// 16x32 message block buffer: byte-serial writes, SHA-1 pad/length insertion
// and a word read port that already reflects a pad being written this cycle.
module sha1_pad_buffer
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [5:0]  wr_idx,
    input  logic [7:0]  wr_byte,
    input  logic        pad_en,
    input  logic [5:0]  len,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] words     [16];
    logic [31:0] words_nxt [16];

    always_comb begin
        for (int w = 0; w < 16; w++) begin
            words_nxt[w] = clr ? 32'd0 : words[w];
        end
        if (wr_en) begin
            words_nxt[wr_idx[5:2]] = (words_nxt[wr_idx[5:2]] & ~byte_lane(8'hFF, wr_idx[1:0]))
                                   | byte_lane(wr_byte, wr_idx[1:0]);
        end
        // Bytes past the message are already zero, so OR-ing the pad byte is enough.
        if (pad_en) begin
            words_nxt[len[5:2]] = words_nxt[len[5:2]] | byte_lane(PAD_BYTE, len[1:0]);
            words_nxt[14]       = 32'd0;
            words_nxt[15]       = {23'd0, len, 3'd0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 16; w++) begin
                words[w] <= 32'd0;
            end
        end else begin
            for (int w = 0; w < 16; w++) begin
                words[w] <= words_nxt[w];
            end
        end
    end

    // Round 1 is fetched during the pad cycle, so bypass the pad byte onto the read.
    assign rd_data = words[rd_addr]
                   | ((pad_en && (rd_addr == len[5:2])) ? byte_lane(PAD_BYTE, len[1:0]) : 32'd0);

endmodule

// File: rtl/sha1_msg_feeder.sv
// Byte-serial message intake, SHA-1 single-block padding and round sequencing
// toward the compression core; captures the resulting digest.
module sha1_msg_feeder
    import sha1_pkg::*;
#(
    parameter int MAX_BYTES  = SHA1_MAX_BYTES,
    parameter int ROUND_LAST = SHA1_ROUND_LAST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [31:0]  core_data,
    output logic [7:0]   core_round,
    output logic [1:0]   core_state,
    output logic         core_en,
    input  logic [159:0] hash_in,
    output logic [159:0] digest_out,
    output logic         digest_valid,
    output logic         busy,
    output logic         err_len
);

    localparam int ROUND_FINAL = ROUND_LAST + 1;

    state_e      state, state_nxt;
    logic [5:0]  count, count_nxt, count_inc;
    logic [7:0]  cnt, cnt_nxt;
    logic        done_wait, done_wait_nxt;
    logic        err_nxt;
    logic        accept;
    logic        capture;
    logic        clr, wr_en, pad_en;
    logic [5:0]  wr_idx;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] core_data_nxt;

    sha1_pad_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_byte (in_data),
        .pad_en  (pad_en),
        .len     (count),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign accept     = in_valid & in_ready;
    assign count_inc  = count + 6'd1;
    assign core_round = cnt;

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        cnt_nxt       = cnt;
        done_wait_nxt = done_wait;
        err_nxt       = err_len;
        capture       = 1'b0;
        clr           = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = count;
        pad_en        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    clr       = 1'b1;
                    wr_en     = 1'b1;
                    wr_idx    = 6'd0;
                    count_nxt = 6'd1;
                    err_nxt   = 1'b0;
                    state_nxt = in_last ? ST_PAD : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en     = 1'b1;
                    count_nxt = count_inc;
                    if (in_last) begin
                        state_nxt = ST_PAD;
                    end else if (count_inc == 6'(MAX_BYTES)) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                pad_en    = 1'b1;
                cnt_nxt   = 8'(SHA1_ROUND_FIRST);
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cnt == 8'(ROUND_FINAL)) begin
                    cnt_nxt       = 8'd0;
                    done_wait_nxt = 1'b0;
                    state_nxt     = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_DONE: begin
                // First cycle lets the finalize round land in the core's hash register.
                if (!done_wait) begin
                    done_wait_nxt = 1'b1;
                end else begin
                    done_wait_nxt = 1'b0;
                    capture       = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        rd_addr       = cnt_nxt[3:0] - 4'd1;
        core_data_nxt = ((state_nxt == ST_RUN) && (cnt_nxt <= 8'd16)) ? rd_data : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            count        <= 6'd0;
            cnt          <= 8'd0;
            done_wait    <= 1'b0;
            err_len      <= 1'b0;
            in_ready     <= 1'b0;
            core_en      <= 1'b0;
            core_data    <= 32'd0;
            core_state   <= 2'd0;
            busy         <= 1'b0;
            digest_out   <= 160'd0;
            digest_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            cnt          <= cnt_nxt;
            done_wait    <= done_wait_nxt;
            err_len      <= err_nxt;
            in_ready     <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
            core_en      <= (state_nxt == ST_RUN);
            core_data    <= core_data_nxt;
            core_state   <= core_state_enc(state_nxt);
            busy         <= (state_nxt != ST_IDLE);
            digest_valid <= capture;
            if (capture) begin
                digest_out <= hash_in;
            end
        end
    end

endmodule

// File: tb/tb_sha1_msg_feeder.sv
// Scoreboard bench for sha1_msg_feeder: expected round words and digests are
// queued when a message is driven and compared as the DUT emits them.
module tb_sha1_msg_feeder;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [31:0]  core_data;
    logic [7:0]   core_round;
    logic [1:0]   core_state;
    logic         core_en;
    logic [159:0] hash_in;
    logic [159:0] digest_out;
    logic         digest_valid;
    logic         busy;
    logic         err_len;

    sha1_msg_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .core_data    (core_data),
        .core_round   (core_round),
        .core_state   (core_state),
        .core_en      (core_en),
        .hash_in      (hash_in),
        .digest_out   (digest_out),
        .digest_valid (digest_valid),
        .busy         (busy),
        .err_len      (err_len)
    );

    typedef struct {
        logic [7:0]  rnd;
        logic [31:0] dat;
    } rexp_t;

    rexp_t        exp_q[$];
    logic [159:0] dig_q[$];
    logic [7:0]   msg[$];
    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;
    int           last_acc = 0;
    int           last_dv  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [159:0] rand160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core stand-in: noise while rounds run, the queued digest once enables stop.
    initial forever begin
        @(negedge clk);
        hash_in = (core_en || dig_q.size() == 0) ? rand160() : dig_q[0];
    end

    task automatic push_exp(input logic [159:0] tgt);
        logic [7:0] blk [64];
        rexp_t      e;
        int         len;
        len = msg.size();
        for (int i = 0; i < 64; i++) blk[i] = 8'd0;
        for (int i = 0; i < len; i++) blk[i] = msg[i];
        blk[len] = 8'h80;
        blk[62]  = 8'((len * 8) >> 8);
        blk[63]  = 8'((len * 8) & 255);
        for (int r = 1; r <= 81; r++) begin
            e.rnd = 8'(r);
            e.dat = (r <= 16) ? {blk[4*(r-1)], blk[4*(r-1)+1], blk[4*(r-1)+2], blk[4*(r-1)+3]} : 32'd0;
            exp_q.push_back(e);
        end
        dig_q.push_back(tgt);
    endtask

    initial forever begin
        rexp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (core_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_en", core_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("round", core_round, e.rnd);
                    chk("data", core_data, e.dat);
                    chk("state_run", core_state, 2);
                end
            end
            if (digest_valid) begin
                if (dig_q.size() == 0) begin
                    chk("unexp_dv", digest_valid, 0);
                end else begin
                    chk("digest", digest_out, dig_q.pop_front());
                    chk("latency", cyc - last_acc, 84);
                    chk("busy_dv", busy, 0);
                    chk("rdy_dv", in_ready, 1);
                end
                last_dv = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last, output int acc);
        int n;
        acc = -1;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        last_acc = acc;
    endtask

    task automatic send_msg(input int n, input logic use_last, output int first_acc);
        int a;
        first_acc = -1;
        for (int i = 0; i < n; i++) begin
            send_byte(msg[i], use_last && (i == n - 1), a);
            if (i == 0) first_acc = a;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((dig_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", dig_q.size(), 0);
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    initial begin
        int acc;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", core_en, 0);
        chk("rst_state", core_state, 0);
        chk("rst_digest", digest_out, 0);
        chk("rst_err", err_len, 0);
        rst_n = 1'b1;

        // "abc"
        set_abc();
        push_exp(rand160());
        send_msg(3, 1'b1, acc);
        @(negedge clk);
        chk("rdy_after_last", in_ready, 0);
        wait_done();

        // 55 bytes, last on the 55th
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'(i));
        push_exp(rand160());
        send_msg(55, 1'b1, acc);
        @(negedge clk);
        chk("rdy_after_55", in_ready, 0);
        chk("pad_state", core_state, 1);
        chk("err_55", err_len, 0);
        wait_done();

        // 60 bytes offered without in_last: truncated at 55
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'(8'hA0 + i));
        push_exp(rand160());
        send_msg(55, 1'b0, acc);
        @(negedge clk);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rdy_trunc", in_ready, 0);
            @(negedge clk);
        end
        chk("err_set", err_len, 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_done();
        chk("err_sticky", err_len, 1);

        // single byte 0xFF
        chk("busy_idle", busy, 0);
        msg.delete();
        msg.push_back(8'hFF);
        push_exp(rand160());
        send_msg(1, 1'b1, acc);
        chk("busy_acc", busy, 1);
        chk("err_clr", err_len, 0);
        wait_done();

        // reset in the middle of a run
        set_abc();
        push_exp(rand160());
        send_msg(3, 1'b1, acc);
        n = 0;
        while (!(core_en && core_round == 8'd40) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rnd40_seen", core_round, 40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_en", core_en, 0);
        chk("mrst_round", core_round, 0);
        chk("mrst_dv", digest_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", in_ready, 0);
        exp_q.delete();
        dig_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_abc();
        push_exp(rand160());
        send_msg(3, 1'b1, acc);
        wait_done();

        // back-to-back: next first byte lands in the digest_valid cycle
        set_abc();
        push_exp(rand160());
        send_msg(3, 1'b1, acc);
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'(8'h30 + 7 * i));
        push_exp(rand160());
        send_msg(5, 1'b1, acc);
        chk("b2b_accept", acc, last_dv + 1);
        wait_done();

        chk("exp_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sha1_msg_feeder.md
Name: sha1_msg_feeder

Overview:
Initiator side of the SHA-1 core's word/round interface. It accepts a byte-serial message over a valid/ready handshake and buffers it as one 512-bit block. It applies SHA-1 padding (0x80, zeros, 64-bit big-endian bit length) and then drives the compression core with core_data/core_round/core_en for rounds 1..81. It captures the core's 160-bit hash output and presents it as the digest. Single-block messages only (1..55 bytes), matching the core's non-chaining h registers.

Parameters:
MAX_BYTES, 55, largest accepted message length; fixed by the single-block padding limit.
ROUND_LAST, 80, last compression round; round ROUND_LAST+1 triggers the core's finalize.

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  message byte
in_valid  in  1  in_data valid
in_last  in  1  qualifies final byte of message
in_ready  out  1  feeder can accept a byte
core_data  out  32  word to core (input_data)
core_round  out  8  round number to core (round)
core_state  out  2  FSM encoding to core (state)
core_en  out  1  core compute_enable
hash_in  in  160  core hash output
digest_out  out  160  captured digest {h0..h4}
digest_valid  out  1  one-cycle pulse, digest_out updated
busy  out  1  high in any state except IDLE
err_len  out  1  sticky: message truncated at MAX_BYTES

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; buffer words, byte count and round counter to 0; in_ready=0 during reset; core_en=0, core_round=0, core_data=0, core_state=0; digest_out=0, digest_valid=0, err_len=0, busy=0.
- Reset mid-operation: same values, effective immediately. No partial digest is emitted.
- FSM states and core_state encoding: IDLE=0, LOAD=1, RUN=2, DONE=3. All outputs are registered.
- IDLE:
  - in_ready=1.
  - First accepted byte (in_valid&in_ready) clears err_len and the buffer, stores the byte at index 0, count=1.
  - Next state is LOAD, or PAD if in_last.
- LOAD:
  - in_ready=1 while count<MAX_BYTES.
  - Byte i is stored big-endian: word[i/4] bits [31-8*(i%4) -: 8].
  - An accepted byte with in_last goes to PAD.
  - The 55th byte accepted without in_last is treated as last, sets err_len and goes to PAD.
  - in_ready=0 from the cycle after the final byte until IDLE.
- PAD (internal sub-phase of LOAD, 1 cycle, core_state stays 1):
  - byte[len]=0x80; bytes len+1..55 stay 0.
  - word14=0; word15=len*8 (16-bit product, zero-extended).
  - round counter=1.
- RUN:
  - Each cycle core_en=1 and core_round=counter.
  - core_data=word[counter-1] for counter 1..16, and 0 for 17..81 (the core expands W internally).
  - Counter increments 1..81; after presenting 81, go to DONE.
  - Exactly 81 consecutive enable cycles; no gaps.
- DONE:
  - core_en=0, core_round=0.
  - Wait one cycle for the core's hash register, sample hash_in into digest_out at the end of that cycle.
  - digest_valid=1 for the following cycle, concurrent with the return to IDLE.
  - A byte may be accepted in that same cycle, because IDLE logic is active.
- Latency: from the edge accepting the last byte to digest_valid high is 1 (PAD) + 81 (RUN) + 1 (DONE) + 1 = 84 cycles.
- in_valid is ignored when in_ready=0; no byte is dropped or double-stored.
- Empty messages are unsupported: the first accepted byte always starts a message.

Decomposition:
- Shared package sha1_pkg: FSM state enum/encodings, round constants (ROUND_FIRST=1, ROUND_LAST=80, ROUND_FINAL=81), MAX_BYTES, SHA-1 IV constants, pad byte 0x80.
- One natural sub-module, sha1_pad_buffer: a 16x32 block buffer with byte-write port, pad/length insertion and word read port. The FSM and counters stay in the top.

Test Plan:
- "abc" (0x61,0x62,0x63 last) -> core_data rounds 1..16 = 0x61626380, 0x00000000 x13, 0x00000000, 0x00000018; core_round counts 1..81 contiguous; digest_valid 84 cycles after the last byte, with digest_out = hash_in sampled in DONE.
- 55 bytes 0x00..0x36, last on 55th -> word13=0x34353680, word14=0, word15=0x000001B8; err_len=0; in_ready low after the 55th byte.
- 60 bytes, in_last never asserted -> only 55 accepted, in_ready=0 from byte 56, err_len=1 through DONE; err_len clears on the next message's first byte.
- Single byte 0xFF with in_valid toggling randomly before it -> word0=0xFF800000, word15=0x00000008; busy rises on acceptance and falls with digest_valid.
- rst_n asserted at core_round=40 -> core_en, core_round, digest_valid, busy are 0 immediately (async); after release, "abc" runs and produces the same sequence as scenario 1.
- Back-to-back: new message byte presented during the digest_valid cycle -> accepted that cycle; second run identical to a standalone run.
